bms_mode_fsm: RTL and testbench

BMS_MODE_FSM -- requirements
Module: bms_mode_fsm

---
 rtl/bms_pkg.sv | 31 +++
 rtl/bms_debounce.sv | 33 +++
 rtl/bms_mode_fsm.sv | 116 +++++++++++
 tb/tb_bms_mode_fsm.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bms_pkg.sv
// Shared definitions for the BMS mode controller: state codes, fault bit
// positions, default timing and SoC hysteresis thresholds.
package bms_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHARGE    = 3'd1,
        ST_DISCHARGE = 3'd2,
        ST_DWELL     = 3'd3,
        ST_FAULT     = 3'd4
    } bms_state_t;

    localparam int FAULT_OV = 0;
    localparam int FAULT_UV = 1;
    localparam int FAULT_OT = 2;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int DWELL_CYCLES_DEF    = 16;

    localparam logic [7:0] SOC_MAX          = 8'd100;
    localparam logic [7:0] SOC_FULL_DEF     = 8'd100;
    localparam logic [7:0] SOC_RECHARGE_DEF = 8'd95;
    localparam logic [7:0] SOC_EMPTY_DEF    = 8'd5;
    localparam logic [7:0] SOC_RESUME_DEF   = 8'd10;

    // Estimator can overshoot; clamp before any threshold compare.
    function automatic logic [7:0] soc_sat(input logic [7:0] soc);
        return (soc > SOC_MAX) ? SOC_MAX : soc;
    endfunction

endpackage

// File: rtl/bms_debounce.sv
// Level debouncer: output follows raw only after raw has disagreed with it
// for DEBOUNCE_CYCLES consecutive samples.
module bms_debounce
    import bms_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (raw == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= raw;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bms_mode_fsm.sv
// Battery mode sequencer: debounced charge/load requests, SoC hysteresis,
// dead-time between power modes and a sticky fault state.
//
// state        | meaning
// IDLE         | both paths off, waiting for a debounced request
// CHARGE       | charge contactor enabled
// DISCHARGE    | load contactor enabled
// DWELL        | dead-time, both enables low for DWELL_CYCLES cycles
// FAULT        | fault seen, waits for clean flags plus operator clear
module bms_mode_fsm
    import bms_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int         DWELL_CYCLES    = DWELL_CYCLES_DEF,
    parameter logic [7:0] SOC_FULL        = SOC_FULL_DEF,
    parameter logic [7:0] SOC_RECHARGE    = SOC_RECHARGE_DEF,
    parameter logic [7:0] SOC_EMPTY       = SOC_EMPTY_DEF,
    parameter logic [7:0] SOC_RESUME      = SOC_RESUME_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       charger_present,
    input  logic       load_request,
    input  logic [7:0] soc_percent,
    input  logic [2:0] fault_flags,
    input  logic       fault_clear,
    output logic       charge_en_fsm,
    output logic       discharge_en_fsm,
    output logic [2:0] bms_state,
    output logic [2:0] fault_latched
);

    localparam int            DW        = $clog2(DWELL_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_TOP = DW'(DWELL_CYCLES - 1);

    bms_state_t    state_q, state_d;
    logic          chg_db, load_db;
    logic [7:0]    soc_s;
    logic [DW-1:0] dwell_cnt;
    logic          fault_exit;

    bms_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_chg (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (charger_present),
        .level (chg_db)
    );

    bms_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (load_request),
        .level (load_db)
    );

    assign soc_s = soc_sat(soc_percent);

    always_comb begin
        state_d = state_q;
        if (|fault_flags) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Charger wins when both requests are active.
                    if (chg_db && (soc_s < SOC_RECHARGE))
                        state_d = ST_CHARGE;
                    else if (load_db && !chg_db && (soc_s > SOC_RESUME))
                        state_d = ST_DISCHARGE;
                end
                ST_CHARGE: begin
                    if ((soc_s >= SOC_FULL) || !chg_db)
                        state_d = ST_DWELL;
                end
                ST_DISCHARGE: begin
                    if ((soc_s <= SOC_EMPTY) || !load_db || chg_db)
                        state_d = ST_DWELL;
                end
                ST_DWELL: begin
                    if (dwell_cnt == '0)
                        state_d = ST_IDLE;
                end
                ST_FAULT: begin
                    if (fault_clear)
                        state_d = ST_DWELL;
                end
                default: state_d = ST_FAULT;
            endcase
        end
    end

    assign fault_exit = (state_q == ST_FAULT) && (state_d == ST_DWELL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            charge_en_fsm    <= 1'b0;
            discharge_en_fsm <= 1'b0;
            fault_latched    <= 3'b000;
            dwell_cnt        <= '0;
        end else begin
            state_q          <= state_d;
            charge_en_fsm    <= (state_d == ST_CHARGE);
            discharge_en_fsm <= (state_d == ST_DISCHARGE);
            fault_latched    <= fault_exit ? 3'b000 : (fault_latched | fault_flags);
            // Reload on every entry so a re-entered dwell always runs in full.
            if ((state_q != ST_DWELL) && (state_d == ST_DWELL))
                dwell_cnt <= DWELL_TOP;
            else if ((state_q == ST_DWELL) && (dwell_cnt != '0))
                dwell_cnt <= dwell_cnt - 1'b1;
        end
    end

    assign bms_state = state_q;

endmodule

// File: tb/tb_bms_mode_fsm.sv
// Directed bench for bms_mode_fsm: vector table for mode sequencing plus
// hand-written sequences for latency, dwell length and async reset.
module tb_bms_mode_fsm;
    import bms_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       charger_present, load_request, fault_clear;
    logic [7:0] soc_percent;
    logic [2:0] fault_flags;
    logic       charge_en_fsm, discharge_en_fsm;
    logic [2:0] bms_state, fault_latched;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] S_IDLE = 3'd0, S_CHG = 3'd1, S_DIS = 3'd2,
                           S_DWL  = 3'd3, S_FLT = 3'd4;

    bms_mode_fsm dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .charger_present  (charger_present),
        .load_request     (load_request),
        .soc_percent      (soc_percent),
        .fault_flags      (fault_flags),
        .fault_clear      (fault_clear),
        .charge_en_fsm    (charge_en_fsm),
        .discharge_en_fsm (discharge_en_fsm),
        .bms_state        (bms_state),
        .fault_latched    (fault_latched)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       chg;
        logic       load;
        logic [7:0] soc;
        logic [2:0] flags;
        logic       clr;
        int         cycles;
        logic [2:0] st;
        logic       ce;
        logic       de;
        logic [2:0] lat;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic chg, input logic load,
                       input logic [7:0] soc, input logic [2:0] flags, input logic clr,
                       input int cyc, input logic [2:0] st, input logic ce,
                       input logic de, input logic [2:0] lat);
        vec_t v;
        v = '{nm, chg, load, soc, flags, clr, cyc, st, ce, de, lat};
        vecs.push_back(v);
    endtask

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk(input string nm, input logic [2:0] st, input logic ce,
                       input logic de, input logic [2:0] lat);
        cmp({nm, ".state"}, 8'(bms_state), 8'(st));
        cmp({nm, ".charge_en"}, 8'(charge_en_fsm), 8'(ce));
        cmp({nm, ".discharge_en"}, 8'(discharge_en_fsm), 8'(de));
        cmp({nm, ".latched"}, 8'(fault_latched), 8'(lat));
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Enables must never overlap, checked on every sampled cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            total++;
            if (charge_en_fsm && discharge_en_fsm) begin
                bad++;
                $display("FAIL enable_overlap: charge_en=%0b discharge_en=%0b expected not both 1",
                         charge_en_fsm, discharge_en_fsm);
            end
        end
    end

    a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
                                   !(charge_en_fsm && discharge_en_fsm));

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dwell_seen;
        logic [2:0] ot, uv, ov;
        ot = '0; ot[FAULT_OT] = 1'b1;
        uv = '0; uv[FAULT_UV] = 1'b1;
        ov = '0; ov[FAULT_OV] = 1'b1;

        rst_n = 1'b0;
        charger_present = 1'b0; load_request = 1'b0; fault_clear = 1'b0;
        soc_percent = 8'd50; fault_flags = 3'b000;
        cycles(3);
        chk("reset", S_IDLE, 1'b0, 1'b0, 3'b000);
        rst_n = 1'b1;
        cycles(2);

        // Charger request: accepted on the 5th edge, not the 4th.
        charger_present = 1'b1;
        cycles(4);
        chk("chg_latency_e4", S_IDLE, 1'b0, 1'b0, 3'b000);
        cycles(1);
        chk("chg_latency_e5", S_CHG, 1'b1, 1'b0, 3'b000);

        // SoC full: count dwell cycles, bounded.
        soc_percent = 8'd100;
        cycles(1);
        dwell_seen = 0;
        for (int i = 0; i < 40 && bms_state == S_DWL; i++) begin
            dwell_seen++;
            cycles(1);
        end
        cmp("full_dwell_len", 8'(dwell_seen), 8'd16);
        chk("full_then_idle", S_IDLE, 1'b0, 1'b0, 3'b000);

        add("settle",        0, 0, 100, 3'b000, 0,  6, S_IDLE, 0, 0, 3'b000);
        add("load_dis",      0, 1,  60, 3'b000, 0,  5, S_DIS,  0, 1, 3'b000);
        add("empty_dwell",   0, 1,   5, 3'b000, 0,  1, S_DWL,  0, 0, 3'b000);
        add("dwell_idle",    0, 1,   8, 3'b000, 0, 16, S_IDLE, 0, 0, 3'b000);
        add("soc8_hold",     0, 1,   8, 3'b000, 0,  5, S_IDLE, 0, 0, 3'b000);
        add("soc10_hold",    0, 1,  10, 3'b000, 0,  2, S_IDLE, 0, 0, 3'b000);
        add("soc11_dis",     0, 1,  11, 3'b000, 0,  1, S_DIS,  0, 1, 3'b000);
        add("ot_fault",      0, 1,  11, ot,     0,  1, S_FLT,  0, 0, ot);
        add("clr_ignored",   0, 1,  11, ot,     1,  1, S_FLT,  0, 0, ot);
        add("flag_low_hold", 0, 1,  11, 3'b000, 0,  2, S_FLT,  0, 0, ot);
        add("clr_accept",    0, 1,  11, 3'b000, 1,  1, S_DWL,  0, 0, 3'b000);
        add("post_flt_dwl",  0, 1,  11, 3'b000, 0, 16, S_IDLE, 0, 0, 3'b000);
        add("resume_dis",    0, 1,  11, 3'b000, 0,  1, S_DIS,  0, 1, 3'b000);
        add("uv_fault",      0, 1,  11, uv,     0,  1, S_FLT,  0, 0, uv);
        add("ov_or_latch",   0, 1,  11, ov,     0,  1, S_FLT,  0, 0, uv | ov);
        add("clr2_accept",   0, 0,  11, 3'b000, 1,  1, S_DWL,  0, 0, 3'b000);
        add("dwell2_idle",   0, 0,  50, 3'b000, 0, 16, S_IDLE, 0, 0, 3'b000);
        add("glitch3",       1, 0,  50, 3'b000, 0,  3, S_IDLE, 0, 0, 3'b000);
        add("glitch_gone",   0, 0,  50, 3'b000, 0,  6, S_IDLE, 0, 0, 3'b000);
        add("both_req_chg",  1, 1,  50, 3'b000, 0,  5, S_CHG,  1, 0, 3'b000);
        add("chg_drop",      0, 1,  50, 3'b000, 0,  5, S_DWL,  0, 0, 3'b000);
        add("dwell3_idle",   0, 1,  50, 3'b000, 0, 16, S_IDLE, 0, 0, 3'b000);
        add("load_dis2",     0, 1,  50, 3'b000, 0,  1, S_DIS,  0, 1, 3'b000);
        add("chg_arr_db",    1, 1,  50, 3'b000, 0,  4, S_DIS,  0, 1, 3'b000);
        add("chg_arr_dwl",   1, 1,  50, 3'b000, 0,  1, S_DWL,  0, 0, 3'b000);
        add("dwell4_mid",    1, 1,  50, 3'b000, 0, 15, S_DWL,  0, 0, 3'b000);
        add("dwell4_idle",   1, 1,  50, 3'b000, 0,  1, S_IDLE, 0, 0, 3'b000);
        add("swap_chg",      1, 1,  50, 3'b000, 0,  1, S_CHG,  1, 0, 3'b000);

        foreach (vecs[i]) begin
            charger_present = vecs[i].chg;
            load_request    = vecs[i].load;
            soc_percent     = vecs[i].soc;
            fault_flags     = vecs[i].flags;
            fault_clear     = vecs[i].clr;
            cycles(vecs[i].cycles);
            chk(vecs[i].name, vecs[i].st, vecs[i].ce, vecs[i].de, vecs[i].lat);
        end
        fault_clear = 1'b0;
        load_request = 1'b0;

        // Async reset between edges while charging.
        #2 rst_n = 1'b0;
        #1 chk("async_rst", S_IDLE, 1'b0, 1'b0, 3'b000);
        soc_percent = 8'd200;
        @(negedge clk);
        rst_n = 1'b1;
        cycles(8);
        chk("soc200_no_chg", S_IDLE, 1'b0, 1'b0, 3'b000);
        soc_percent = 8'd95;
        cycles(2);
        chk("soc95_no_chg", S_IDLE, 1'b0, 1'b0, 3'b000);
        soc_percent = 8'd94;
        cycles(1);
        chk("soc94_chg", S_CHG, 1'b1, 1'b0, 3'b000);

        // Charger held through reset still needs a full re-debounce.
        #3 rst_n = 1'b0;
        soc_percent = 8'd50;
        @(negedge clk);
        rst_n = 1'b1;
        cycles(4);
        chk("redb_e4", S_IDLE, 1'b0, 1'b0, 3'b000);
        cycles(1);
        chk("redb_e5", S_CHG, 1'b1, 1'b0, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
